// File: rtl/irig_b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irig_b_pkg
// Description : Shared IRIG-B constants, types and helpers. The encoder and
//               the decoder both import it, so both agree on frame layout.
// Revision    : 1.0 - initial release
// ============================================================================
package irig_b_pkg;

  // Default bit timing: a 10 ms bit at 100 MHz.
  localparam int DEF_BIT_CYCLES = 1_000_000;
  localparam int DEF_P_HIGH     = 800_000;
  localparam int DEF_ONE_HIGH   = 500_000;
  localparam int DEF_ZERO_HIGH  = 200_000;

  localparam int FRAME_BITS = 100;

  // Symbol types carried by one bit slot.
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    ONE  = 2'd1,
    MARK = 2'd2
  } bit_type_t;

  // Encoder framing states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

  // P-marker positions 0, 9, 19, ... 99; bit 0 is the Pr reference marker.
  localparam logic [99:0] P_MASK = (100'd1 << 0)  | (100'd1 << 9)  |
                                   (100'd1 << 19) | (100'd1 << 29) |
                                   (100'd1 << 39) | (100'd1 << 49) |
                                   (100'd1 << 59) | (100'd1 << 69) |
                                   (100'd1 << 79) | (100'd1 << 89) |
                                   (100'd1 << 99);

  // First (LSB) position of every BCD field; fields are sent LSB first.
  localparam int SEC_UNITS_POS  = 1;
  localparam int SEC_TENS_POS   = 6;
  localparam int MIN_UNITS_POS  = 10;
  localparam int MIN_TENS_POS   = 15;
  localparam int HOUR_UNITS_POS = 20;
  localparam int HOUR_TENS_POS  = 25;
  localparam int DAY_UNITS_POS  = 30;
  localparam int DAY_TENS_POS   = 35;
  localparam int DAY_HUND_POS   = 40;
  localparam int YEAR_UNITS_POS = 50;
  localparam int YEAR_TENS_POS  = 55;

  // Time of day in exactly the BCD digits a frame carries.
  typedef struct packed {
    logic [3:0] sec_units;
    logic [2:0] sec_tens;
    logic [3:0] min_units;
    logic [2:0] min_tens;
    logic [3:0] hour_units;
    logic [1:0] hour_tens;
    logic [3:0] day_units;
    logic [3:0] day_tens;
    logic [1:0] day_hund;
    logic [3:0] year_units;
    logic [3:0] year_tens;
  } time_bcd_t;

  // Double-dabble conversion of 0..999 into three BCD digits.
  function automatic logic [11:0] bin_to_bcd(input logic [9:0] bin);
    logic [21:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (sh[13:10] >= 4'd5) sh[13:10] = sh[13:10] + 4'd3;
      if (sh[17:14] >= 4'd5) sh[17:14] = sh[17:14] + 4'd3;
      if (sh[21:18] >= 4'd5) sh[21:18] = sh[21:18] + 4'd3;
      sh = sh << 1;
    end
    return sh[21:10];
  endfunction

  // Binary time of day to the frame's BCD digit set.
  function automatic time_bcd_t pack_time_bcd(input logic [6:0] sec,
                                               input logic [6:0] min,
                                               input logic [5:0] hour,
                                               input logic [9:0] day,
                                               input logic [7:0] year);
    time_bcd_t  r;
    logic [11:0] s, m, h, d, y;
    s = bin_to_bcd({3'd0, sec});
    m = bin_to_bcd({3'd0, min});
    h = bin_to_bcd({4'd0, hour});
    d = bin_to_bcd(day);
    y = bin_to_bcd({2'd0, year});
    r.sec_units  = s[3:0];
    r.sec_tens   = s[6:4];
    r.min_units  = m[3:0];
    r.min_tens   = m[6:4];
    r.hour_units = h[3:0];
    r.hour_tens  = h[5:4];
    r.day_units  = d[3:0];
    r.day_tens   = d[7:4];
    r.day_hund   = d[9:8];
    r.year_units = y[3:0];
    r.year_tens  = y[7:4];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irig_b_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : irig_b_encoder_if
// Description : Control, time-load and time-code output bundle of the
//               IRIG-B encoder. The master drives controls, the slave (the
//               encoder) drives the time code and framing status.
// Revision    : 1.0 - initial release
// ============================================================================
interface irig_b_encoder_if;
  logic       enable;
  logic       time_load;
  logic [6:0] ld_second;
  logic [6:0] ld_minute;
  logic [5:0] ld_hour;
  logic [9:0] ld_day;
  logic [7:0] ld_year;
  logic       irig_b;
  logic       frame_start;
  logic       bit_strobe;
  logic [6:0] bit_index;
  logic       busy;

  modport master (
    output enable, time_load, ld_second, ld_minute, ld_hour, ld_day, ld_year,
    input  irig_b, frame_start, bit_strobe, bit_index, busy
  );

  modport slave (
    input  enable, time_load, ld_second, ld_minute, ld_hour, ld_day, ld_year,
    output irig_b, frame_start, bit_strobe, bit_index, busy
  );
endinterface
`default_nettype wire

// File: rtl/irig_b_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : irig_b_time_counter
// Description : Loadable binary time-of-day counter with cascaded rollover
//               and the year%4 leap-day rule. A load beats an increment.
// Revision    : 1.0 - initial release
// ============================================================================
module irig_b_time_counter (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       load,
  input  logic       inc,
  input  logic [6:0] ld_second,
  input  logic [6:0] ld_minute,
  input  logic [5:0] ld_hour,
  input  logic [9:0] ld_day,
  input  logic [7:0] ld_year,
  output logic [6:0] second,
  output logic [6:0] minute,
  output logic [5:0] hour,
  output logic [9:0] day,
  output logic [7:0] year
);

  logic [6:0] second_q, second_d;
  logic [6:0] minute_q, minute_d;
  logic [5:0] hour_q, hour_d;
  logic [9:0] day_q, day_d;
  logic [7:0] year_q, year_d;
  logic [9:0] day_last;

  // Last day of the current year; out-of-range values wrap as if at the end.
  assign day_last = (year_q[1:0] == 2'b00) ? 10'd366 : 10'd365;

  // Load or one-second advance with carries rippling second -> year.
  always_comb begin
    second_d = second_q;
    minute_d = minute_q;
    hour_d   = hour_q;
    day_d    = day_q;
    year_d   = year_q;
    if (load) begin
      second_d = ld_second;
      minute_d = ld_minute;
      hour_d   = ld_hour;
      day_d    = ld_day;
      year_d   = ld_year;
    end else if (inc) begin
      if (second_q >= 7'd59) begin
        second_d = 7'd0;
        if (minute_q >= 7'd59) begin
          minute_d = 7'd0;
          if (hour_q >= 6'd23) begin
            hour_d = 6'd0;
            if (day_q >= day_last) begin
              day_d  = 10'd1;
              year_d = (year_q >= 8'd99) ? 8'd0 : year_q + 8'd1;
            end else begin
              day_d = day_q + 10'd1;
            end
          end else begin
            hour_d = hour_q + 6'd1;
          end
        end else begin
          minute_d = minute_q + 7'd1;
        end
      end else begin
        second_d = second_q + 7'd1;
      end
    end
  end

  // Time registers; reset to 00:00:00 on day 1 of year 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      second_q <= 7'd0;
      minute_q <= 7'd0;
      hour_q   <= 6'd0;
      day_q    <= 10'd1;
      year_q   <= 8'd0;
    end else begin
      second_q <= second_d;
      minute_q <= minute_d;
      hour_q   <= hour_d;
      day_q    <= day_d;
      year_q   <= year_d;
    end
  end

  assign second = second_q;
  assign minute = minute_q;
  assign hour   = hour_q;
  assign day    = day_q;
  assign year   = year_q;

endmodule
`default_nettype wire

// File: rtl/irig_b_encoder.sv
`default_nettype none
// ============================================================================
// Module      : irig_b_encoder
// Description : IRIG-B DC-level-shift time-code generator. Emits one 100-bit
//               frame per second from a self-advancing time-of-day counter.
//               All outputs are flops, one cycle behind the bit/cycle
//               counters; the time counter and shadow follow the output
//               timeline so a load on the visible last clock of bit 99 lands
//               in the next frame.
// Revision    : 1.0 - initial release
// ============================================================================
module irig_b_encoder
  import irig_b_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int P_HIGH     = DEF_P_HIGH,
  parameter int ONE_HIGH   = DEF_ONE_HIGH,
  parameter int ZERO_HIGH  = DEF_ZERO_HIGH
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  irig_b_encoder_if.slave   bus
);

  localparam int             CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0]  CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [6:0]     LAST_BIT = 7'(FRAME_BITS - 1);

  enc_state_t    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [6:0]    bit_q, bit_d;
  time_bcd_t     shadow_q, shadow_d;
  logic          irig_b_q, irig_b_d;
  logic          frame_start_q, frame_start_d;
  logic          bit_strobe_q, bit_strobe_d;
  logic [6:0]    bit_index_q, bit_index_d;
  logic          busy_q, busy_d;
  logic          last_clk_q, last_clk_d;

  logic [99:0]   frame_bits;
  bit_type_t     bit_type;
  logic [CW-1:0] high_len;

  logic [6:0]    tc_second;
  logic [6:0]    tc_minute;
  logic [5:0]    tc_hour;
  logic [9:0]    tc_day;
  logic [7:0]    tc_year;

  irig_b_time_counter u_time_counter (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (bus.time_load),
    .inc       (last_clk_q),
    .ld_second (bus.ld_second),
    .ld_minute (bus.ld_minute),
    .ld_hour   (bus.ld_hour),
    .ld_day    (bus.ld_day),
    .ld_year   (bus.ld_year),
    .second    (tc_second),
    .minute    (tc_minute),
    .hour      (tc_hour),
    .day       (tc_day),
    .year      (tc_year)
  );

  // Lay the shadowed BCD digits out at their frame positions.
  always_comb begin
    frame_bits = '0;
    frame_bits[SEC_UNITS_POS  +: 4] = shadow_q.sec_units;
    frame_bits[SEC_TENS_POS   +: 3] = shadow_q.sec_tens;
    frame_bits[MIN_UNITS_POS  +: 4] = shadow_q.min_units;
    frame_bits[MIN_TENS_POS   +: 3] = shadow_q.min_tens;
    frame_bits[HOUR_UNITS_POS +: 4] = shadow_q.hour_units;
    frame_bits[HOUR_TENS_POS  +: 2] = shadow_q.hour_tens;
    frame_bits[DAY_UNITS_POS  +: 4] = shadow_q.day_units;
    frame_bits[DAY_TENS_POS   +: 4] = shadow_q.day_tens;
    frame_bits[DAY_HUND_POS   +: 2] = shadow_q.day_hund;
    frame_bits[YEAR_UNITS_POS +: 4] = shadow_q.year_units;
    frame_bits[YEAR_TENS_POS  +: 4] = shadow_q.year_tens;
  end

  // Classify the current bit and pick its high time.
  always_comb begin
    if (P_MASK[bit_q])           bit_type = MARK;
    else if (frame_bits[bit_q])  bit_type = ONE;
    else                         bit_type = ZERO;
    case (bit_type)
      MARK:    high_len = CW'(P_HIGH);
      ONE:     high_len = CW'(ONE_HIGH);
      default: high_len = CW'(ZERO_HIGH);
    endcase
  end

  // Framing FSM: next state, bit/cycle counters and next output values.
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    bit_d         = bit_q;
    irig_b_d      = 1'b0;
    frame_start_d = 1'b0;
    bit_strobe_d  = 1'b0;
    busy_d        = 1'b0;
    last_clk_d    = 1'b0;
    bit_index_d   = bit_q;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = RUN;
          cyc_d   = '0;
          bit_d   = 7'd0;
        end
      end
      RUN: begin
        busy_d        = 1'b1;
        irig_b_d      = (cyc_q < high_len);
        bit_strobe_d  = (cyc_q == '0);
        frame_start_d = (cyc_q == '0) && (bit_q == 7'd0);
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == LAST_BIT) begin
            // Frames always run to completion; enable only gates the next one.
            bit_d      = 7'd0;
            last_clk_d = 1'b1;
            if (!bus.enable) state_d = IDLE;
          end else begin
            bit_d = bit_q + 7'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot the time counter as BCD on the visible frame_start clock.
  always_comb begin
    shadow_d = shadow_q;
    if (frame_start_q) begin
      shadow_d = pack_time_bcd(tc_second, tc_minute, tc_hour, tc_day, tc_year);
    end
  end

  // State, counters, shadow and output flops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      bit_q         <= 7'd0;
      shadow_q      <= '0;
      irig_b_q      <= 1'b0;
      frame_start_q <= 1'b0;
      bit_strobe_q  <= 1'b0;
      bit_index_q   <= 7'd0;
      busy_q        <= 1'b0;
      last_clk_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      bit_q         <= bit_d;
      shadow_q      <= shadow_d;
      irig_b_q      <= irig_b_d;
      frame_start_q <= frame_start_d;
      bit_strobe_q  <= bit_strobe_d;
      bit_index_q   <= bit_index_d;
      busy_q        <= busy_d;
      last_clk_q    <= last_clk_d;
    end
  end

  assign bus.irig_b      = irig_b_q;
  assign bus.frame_start = frame_start_q;
  assign bus.bit_strobe  = bit_strobe_q;
  assign bus.bit_index   = bit_index_q;
  assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_irig_b_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_irig_b_encoder
// Description : Directed self-checking bench for irig_b_encoder with short
//               bit periods (100 clocks per bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irig_b_encoder;

  logic sys_clk;
  logic sys_rst_n;

  irig_b_encoder_if bus ();

  irig_b_encoder #(
    .BIT_CYCLES (100),
    .P_HIGH     (80),
    .ONE_HIGH   (50),
    .ZERO_HIGH  (20)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int          errors;
  int          checks;
  int          hi_len [100];
  logic [99:0] cap_mk, cap_one;
  logic [99:0] exp_mk, exp_one;
  int          strobe_err;
  int          len_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_load(input int s, input int m, input int h, input int d, input int y);
    bus.ld_second = 7'(s);
    bus.ld_minute = 7'(m);
    bus.ld_hour   = 6'(h);
    bus.ld_day    = 10'(d);
    bus.ld_year   = 8'(y);
  endtask

  task automatic put_field(input int pos, input int val, input int nbits);
    for (int k = 0; k < nbits; k++) exp_one[pos + k] = ((val >> k) & 1) != 0;
  endtask

  // Expected frame built from decimal digits of the time.
  task automatic build_exp(input int s, input int m, input int h, input int d, input int y);
    int marks [11];
    marks = '{0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99};
    exp_mk  = '0;
    exp_one = '0;
    foreach (marks[i]) exp_mk[marks[i]] = 1'b1;
    put_field(1,  s % 10, 4);  put_field(6,  s / 10, 3);
    put_field(10, m % 10, 4);  put_field(15, m / 10, 3);
    put_field(20, h % 10, 4);  put_field(25, h / 10, 2);
    put_field(30, d % 10, 4);  put_field(35, (d / 10) % 10, 4);
    put_field(40, d / 100, 2);
    put_field(50, y % 10, 4);  put_field(55, y / 10, 4);
  endtask

  function automatic int dec(input int pos, input int nbits);
    int v;
    v = 0;
    for (int k = 0; k < nbits; k++) if (cap_one[pos + k]) v += (1 << k);
    return v;
  endfunction

  // Capture one frame from its frame_start clock; optionally drop enable at
  // a bit and/or strobe time_load on the last clock of bit 99.
  task automatic capture(input int drop_at, input bit do_load);
    int n;
    int hi;
    n = 0;
    while (bus.frame_start !== 1'b1 && n < 20000) begin
      @(negedge sys_clk);
      n++;
    end
    check("frame_start seen", bus.frame_start, 1'b1);
    strobe_err = 0;
    len_err    = 0;
    cap_mk     = '0;
    cap_one    = '0;
    for (int b = 0; b < 100; b++) begin
      if (bus.bit_strobe !== 1'b1 || bus.bit_index !== 7'(b)) strobe_err++;
      if (b == drop_at) bus.enable = 1'b0;
      hi = 0;
      for (int c = 0; c < 100; c++) begin
        if (bus.irig_b === 1'b1) hi++;
        if (c > 0 && (bus.bit_strobe !== 1'b0 || bus.frame_start !== 1'b0)) strobe_err++;
        if (bus.busy !== 1'b1) strobe_err++;
        if (do_load && b == 99 && c == 99) bus.time_load = 1'b1;
        @(negedge sys_clk);
        bus.time_load = 1'b0;
      end
      hi_len[b] = hi;
      case (hi)
        80:      cap_mk[b]  = 1'b1;
        50:      cap_one[b] = 1'b1;
        20:      ;
        default: len_err++;
      endcase
    end
  endtask

  task automatic check_frame(input string tag, input int s, input int m, input int h,
                             input int d, input int y);
    build_exp(s, m, h, d, y);
    check({tag, " markers"}, cap_mk, exp_mk);
    check({tag, " data"}, cap_one, exp_one);
    check({tag, " strobe/busy errs"}, strobe_err, 0);
    check({tag, " bad high lengths"}, len_err, 0);
  endtask

  initial begin
    int n;
    int stray;
    errors = 0;
    checks = 0;
    sys_rst_n     = 1'b0;
    bus.enable    = 1'b0;
    bus.time_load = 1'b0;
    set_load(0, 0, 0, 1, 0);

    // Reset with enable low.
    repeat (3) @(negedge sys_clk);
    check("reset outputs", {bus.irig_b, bus.frame_start, bus.bit_strobe, bus.busy, bus.bit_index}, 0);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    check("idle irig_b", bus.irig_b, 1'b0);
    check("idle busy", bus.busy, 1'b0);
    check("idle bit_index", bus.bit_index, 7'd0);

    // Load 12:34:56 day 123 year 24, then enable.
    set_load(12, 34, 56 - 22, 123, 24);
    set_load(56, 34, 12, 123, 24);
    bus.time_load = 1'b1;
    @(negedge sys_clk);
    bus.time_load = 1'b0;
    bus.enable    = 1'b1;
    @(negedge sys_clk);
    check("start latency busy not yet", bus.busy, 1'b0);
    @(negedge sys_clk);
    check("start outputs", {bus.irig_b, bus.frame_start, bus.bit_strobe, bus.busy}, 4'b1111);
    check("start bit_index", bus.bit_index, 7'd0);

    // Frame 1; on its last clock load 23:59:59 day 366 year 24.
    set_load(59, 59, 23, 366, 24);
    capture(-1, 1'b1);
    check("f1 bit0 high", hi_len[0], 80);
    check("f1 bit1 high", hi_len[1], 20);
    check("f1 bit2 high", hi_len[2], 50);
    check("f1 bit3 high", hi_len[3], 50);
    check("f1 bit4 high", hi_len[4], 20);
    check("f1 bit40 high", hi_len[40], 50);
    check_frame("f1", 56, 34, 12, 123, 24);
    check("f1 second", dec(1, 4) + 10 * dec(6, 3), 56);
    check("f1 minute", dec(10, 4) + 10 * dec(15, 3), 34);
    check("f1 hour", dec(20, 4) + 10 * dec(25, 2), 12);
    check("f1 day", dec(30, 4) + 10 * dec(35, 4) + 100 * dec(40, 2), 123);
    check("f1 year", dec(50, 4) + 10 * dec(55, 4), 24);

    // Frame 2 carries the load, not load+1.
    capture(-1, 1'b0);
    check_frame("f2 load wins", 59, 59, 23, 366, 24);

    // Frame 3 rolls over the leap year; load the non-leap case at its end.
    set_load(59, 59, 23, 365, 23);
    capture(-1, 1'b1);
    check_frame("f3 leap rollover", 0, 0, 0, 1, 25);

    capture(-1, 1'b0);
    check_frame("f4 loaded", 59, 59, 23, 365, 23);

    // Frame 5 rolls the non-leap year; enable drops at bit 40.
    capture(40, 1'b0);
    check_frame("f5 rollover", 0, 0, 0, 1, 24);
    check("post-frame busy", bus.busy, 1'b0);
    check("post-frame irig_b", bus.irig_b, 1'b0);
    stray = 0;
    repeat (300) begin
      if (bus.irig_b !== 1'b0 || bus.busy !== 1'b0 || bus.frame_start !== 1'b0) stray++;
      @(negedge sys_clk);
    end
    check("idle after drop", stray, 0);

    // Reset mid-frame at bit 57.
    bus.enable = 1'b1;
    n = 0;
    while (bus.bit_index !== 7'd57 && n < 8000) begin
      @(negedge sys_clk);
      n++;
    end
    check("reached bit 57", bus.bit_index, 7'd57);
    #2 sys_rst_n = 1'b0;
    #1 check("async reset outputs", {bus.irig_b, bus.frame_start, bus.bit_strobe, bus.busy, bus.bit_index}, 0);
    @(negedge sys_clk);
    check("held reset outputs", {bus.irig_b, bus.frame_start, bus.bit_strobe, bus.busy, bus.bit_index}, 0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("restart latency", bus.frame_start, 1'b0);
    @(negedge sys_clk);
    check("restart frame_start", {bus.frame_start, bus.busy, bus.bit_index}, {1'b1, 1'b1, 7'd0});
    capture(0, 1'b0);
    check_frame("after reset", 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
